sha1_w_schedule: RTL and testbench

//   SHA-1 message-schedule stage, directly upstream of sha1_round.
//   - Accepts one padded 512-bit message block.
//   - Streams W_t for t = 0..NUM_ROUNDS-1, one word per transfer, each tagged with its round index t.
//   - Words are held in a 16x32 sliding window; sha1_round consumes w_data/w_t as its w0/t inputs.

---
 rtl/sha1_w_schedule_if.sv | 24 ++
 rtl/sha1_w_schedule.sv | 95 +++++++++
 tb/tb_sha1_w_schedule.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha1_w_schedule_if.sv
// Block-in / word-out bus of the SHA-1 message-schedule stage.
// slave = schedule stage, master = block source plus sha1_round consumer.
interface sha1_w_schedule_if #(
   parameter int T_W = 9
);
   logic           blk_valid;
   logic           blk_ready;
   logic [511:0]   blk_data;
   logic           w_valid;
   logic           w_ready;
   logic [31:0]    w_data;
   logic [T_W-1:0] w_t;
   logic           w_last;

   modport master (
      output blk_valid, blk_data, w_ready,
      input  blk_ready, w_valid, w_data, w_t, w_last
   );

   modport slave (
      input  blk_valid, blk_data, w_ready,
      output blk_ready, w_valid, w_data, w_t, w_last
   );
endinterface

// File: rtl/sha1_w_schedule.sv
// SHA-1 message schedule: loads one 512-bit block and streams W_0..W_{NUM_ROUNDS-1}
// from a 16-word sliding window. Define SHA1_WSCHED_STALL_EN to let w_ready stall the stream.
module sha1_w_schedule #(
   parameter int NUM_ROUNDS = 80,
   parameter int T_W        = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   sha1_w_schedule_if.slave  bus
);

   localparam logic [0:0]     IDLE   = 1'b0;
   localparam logic [0:0]     RUN    = 1'b1;
   localparam logic [T_W-1:0] T_LAST = T_W'(NUM_ROUNDS - 1);
   localparam logic [T_W-1:0] T_PREV = T_W'(NUM_ROUNDS - 2);

   function automatic logic [31:0] rotl1(input logic [31:0] x);
      return {x[30:0], x[31]};
   endfunction

   // W_{t+16} from the four taps currently at window positions 13, 8, 2 and 0.
   function automatic logic [31:0] expand(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
      return rotl1(a ^ b ^ c ^ d);
   endfunction

   logic [0:0]     state_p0;
   logic [31:0]    win_p0 [16];
   logic [T_W-1:0] t_p0;
   logic           last_p0;

   logic           in_idle;
   logic           in_run;
   logic           accept;
   logic           adv;
   logic           adv_last;
   logic [31:0]    w_next;

   assign in_idle  = (state_p0 == IDLE);
   assign in_run   = (state_p0 == RUN);
   assign accept   = in_idle & bus.blk_valid;
   assign adv_last = adv & last_p0;
   assign w_next   = expand(win_p0[13], win_p0[8], win_p0[2], win_p0[0]);

`ifdef SHA1_WSCHED_STALL_EN
   assign adv = in_run & bus.w_ready;
`else
   logic unused_w_ready;
   assign unused_w_ready = bus.w_ready;
   assign adv = in_run;
`endif

   // stage p0: control (state, round index, last flag)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p0 <= IDLE;
         t_p0     <= '0;
         last_p0  <= 1'b0;
      end else if (accept) begin
         state_p0 <= RUN;
         t_p0     <= '0;
         last_p0  <= (NUM_ROUNDS == 1);
      end else if (adv_last) begin
         state_p0 <= IDLE;
         t_p0     <= '0;
         last_p0  <= 1'b0;
      end else if (adv) begin
         t_p0     <= t_p0 + T_W'(1);
         last_p0  <= (t_p0 == T_PREV);
      end
   end

   // stage p0: 16-word sliding window, s[0] is the word on the output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) win_p0[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < 16; i++) win_p0[i] <= bus.blk_data[511 - 32*i -: 32];
      end else if (adv) begin
         for (int i = 0; i < 15; i++) win_p0[i] <= win_p0[i + 1];
         win_p0[15] <= w_next;
      end
   end

   // blk_ready is forced low while rst_n is asserted
   assign bus.blk_ready = rst_n & in_idle;
   assign bus.w_valid   = in_run;
   assign bus.w_data    = win_p0[0];
   assign bus.w_t       = t_p0;
   assign bus.w_last    = last_p0;

   logic unused_t_last;
   assign unused_t_last = ^T_LAST;

endmodule

// File: tb/tb_sha1_w_schedule.sv
// Directed bench for sha1_w_schedule: table of hand-computed W words plus
// back-to-back, stall, mid-block reset and RUN-phase disturbance sequences.
module tb_sha1_w_schedule;

   localparam int T_W = 9;

   typedef struct {
      logic [511:0] blk;
      int           t;
      logic [31:0]  w;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [31:0]  mw  [80];
   logic [31:0]  got [80];
   logic [511:0] abc_blk, zero_blk, ones_blk;

   sha1_w_schedule_if #(.T_W(T_W)) bus_if ();

   sha1_w_schedule #(.NUM_ROUNDS(80), .T_W(T_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] rl1(input logic [31:0] x);
      return {x[30:0], x[31]};
   endfunction

   task automatic fill_model(input logic [511:0] b);
      for (int t = 0; t < 80; t++) begin
         if (t < 16) mw[t] = b[511 - 32*t -: 32];
         else        mw[t] = rl1(mw[t-3] ^ mw[t-8] ^ mw[t-14] ^ mw[t-16]);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full block with blk_valid/blk_data disturbed during t=10..29.
   task automatic run_stream(input logic [511:0] b);
      fill_model(b);
      bus_if.blk_data  = b;
      bus_if.blk_valid = 1'b1;
      chk("pre_blk_ready", 32'(bus_if.blk_ready), 32'd1);
      step();
      for (int t = 0; t < 80; t++) begin
         bus_if.blk_valid = (t >= 10 && t < 30);
         bus_if.blk_data  = (t >= 10 && t < 30) ? ~b : b;
         chk($sformatf("s_valid_t%0d", t), 32'(bus_if.w_valid), 32'd1);
         chk($sformatf("s_t_t%0d", t), 32'(bus_if.w_t), 32'(t));
         chk($sformatf("s_data_t%0d", t), bus_if.w_data, mw[t]);
         chk($sformatf("s_last_t%0d", t), 32'(bus_if.w_last), 32'(t == 79));
         chk($sformatf("s_bready_t%0d", t), 32'(bus_if.blk_ready), 32'd0);
         got[t] = bus_if.w_data;
         step();
      end
      bus_if.blk_valid = 1'b0;
      bus_if.blk_data  = b;
      chk("post_valid", 32'(bus_if.w_valid), 32'd0);
      chk("post_blk_ready", 32'(bus_if.blk_ready), 32'd1);
      chk("post_last", 32'(bus_if.w_last), 32'd0);
   endtask

   vec_t vt [$];
   bit   drained;

   initial begin
      checks = 0;
      errors = 0;
      abc_blk  = '0;
      abc_blk[511:480] = 32'h61626380;
      abc_blk[31:0]    = 32'h00000018;
      zero_blk = '0;
      ones_blk = '1;

      vt.push_back('{abc_blk, 0,  32'h61626380});
      vt.push_back('{abc_blk, 1,  32'h00000000});
      vt.push_back('{abc_blk, 15, 32'h00000018});
      vt.push_back('{abc_blk, 16, 32'hC2C4C700});
      vt.push_back('{abc_blk, 17, 32'h00000000});
      vt.push_back('{abc_blk, 18, 32'h00000030});
      vt.push_back('{abc_blk, 19, 32'h85898E01});
      vt.push_back('{zero_blk, 0,  32'h00000000});
      vt.push_back('{zero_blk, 40, 32'h00000000});
      vt.push_back('{zero_blk, 79, 32'h00000000});
      vt.push_back('{ones_blk, 0,  32'hFFFFFFFF});
      vt.push_back('{ones_blk, 15, 32'hFFFFFFFF});
      vt.push_back('{ones_blk, 16, 32'h00000000});
      vt.push_back('{ones_blk, 19, 32'hFFFFFFFF});

      // reset state
      rst_n            = 1'b1;
      bus_if.blk_valid = 1'b0;
      bus_if.blk_data  = '0;
      bus_if.w_ready   = 1'b1;
      #1 rst_n = 1'b0;
      step();
      step();
      chk("rst_valid", 32'(bus_if.w_valid), 32'd0);
      chk("rst_data", bus_if.w_data, 32'd0);
      chk("rst_t", 32'(bus_if.w_t), 32'd0);
      chk("rst_last", 32'(bus_if.w_last), 32'd0);
      chk("rst_blk_ready", 32'(bus_if.blk_ready), 32'd0);
      rst_n = 1'b1;
      step();
      chk("idle_blk_ready", 32'(bus_if.blk_ready), 32'd1);
      chk("idle_valid", 32'(bus_if.w_valid), 32'd0);

      // table of hand-computed words
      for (int i = 0; i < vt.size(); i++) begin
         if (i == 0 || vt[i].blk != vt[i-1].blk) run_stream(vt[i].blk);
         chk($sformatf("vec%0d_t%0d", i, vt[i].t), got[vt[i].t], vt[i].w);
      end

      // back-to-back with blk_valid held high
      fill_model(abc_blk);
      bus_if.blk_data  = abc_blk;
      bus_if.blk_valid = 1'b1;
      step();
      bus_if.blk_data = zero_blk;
      for (int t = 0; t < 80; t++) begin
         chk($sformatf("b2b1_t_%0d", t), 32'(bus_if.w_t), 32'(t));
         chk($sformatf("b2b1_data_%0d", t), bus_if.w_data, mw[t]);
         chk($sformatf("b2b1_bready_%0d", t), 32'(bus_if.blk_ready), 32'd0);
         step();
      end
      chk("b2b_bubble_valid", 32'(bus_if.w_valid), 32'd0);
      chk("b2b_bubble_ready", 32'(bus_if.blk_ready), 32'd1);
      step();
      bus_if.blk_valid = 1'b0;
      for (int t = 0; t < 80; t++) begin
         chk($sformatf("b2b2_valid_%0d", t), 32'(bus_if.w_valid), 32'd1);
         chk($sformatf("b2b2_t_%0d", t), 32'(bus_if.w_t), 32'(t));
         chk($sformatf("b2b2_data_%0d", t), bus_if.w_data, 32'd0);
         step();
      end
      chk("b2b2_end_valid", 32'(bus_if.w_valid), 32'd0);

      // w_ready low for 5 cycles at t=17
      fill_model(abc_blk);
      bus_if.blk_data  = abc_blk;
      bus_if.blk_valid = 1'b1;
      step();
      bus_if.blk_valid = 1'b0;
      repeat (17) step();
      chk("stall_at_t", 32'(bus_if.w_t), 32'd17);
      bus_if.w_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
`ifdef SHA1_WSCHED_STALL_EN
         chk($sformatf("stall_hold_t_%0d", k), 32'(bus_if.w_t), 32'd17);
         chk($sformatf("stall_hold_d_%0d", k), bus_if.w_data, 32'h00000000);
         chk($sformatf("stall_hold_v_%0d", k), 32'(bus_if.w_valid), 32'd1);
`else
         chk($sformatf("nostall_t_%0d", k), 32'(bus_if.w_t), 32'(17 + k));
         chk($sformatf("nostall_d_%0d", k), bus_if.w_data, mw[17 + k]);
`endif
      end
      bus_if.w_ready = 1'b1;
      step();
`ifdef SHA1_WSCHED_STALL_EN
      chk("stall_resume_t", 32'(bus_if.w_t), 32'd18);
      chk("stall_resume_d", bus_if.w_data, 32'h00000030);
`else
      chk("nostall_resume_t", 32'(bus_if.w_t), 32'd23);
      chk("nostall_resume_d", bus_if.w_data, mw[23]);
`endif
      drained = 1'b0;
      for (int i = 0; i < 200 && !drained; i++) begin
         if (!bus_if.w_valid) drained = 1'b1;
         else step();
      end
      chk("stall_drain", 32'(drained), 32'd1);

      // asynchronous reset in the middle of a block
      fill_model(abc_blk);
      bus_if.blk_data  = abc_blk;
      bus_if.blk_valid = 1'b1;
      step();
      bus_if.blk_valid = 1'b0;
      repeat (40) step();
      chk("pre_rst_t", 32'(bus_if.w_t), 32'd40);
      chk("pre_rst_d", bus_if.w_data, mw[40]);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus_if.w_valid), 32'd0);
      chk("arst_t", 32'(bus_if.w_t), 32'd0);
      chk("arst_data", bus_if.w_data, 32'd0);
      chk("arst_blk_ready", 32'(bus_if.blk_ready), 32'd0);
      step();
      step();
      chk("arst_hold_valid", 32'(bus_if.w_valid), 32'd0);
      rst_n = 1'b1;
      step();
      chk("after_rst_ready", 32'(bus_if.blk_ready), 32'd1);
      chk("after_rst_valid", 32'(bus_if.w_valid), 32'd0);
      run_stream(abc_blk);
      chk("after_rst_w0", got[0], 32'h61626380);
      chk("after_rst_w19", got[19], 32'h85898E01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
